// File: rtl/fp_add_sub_pipe.sv
// Pipelined IEEE-754 adder/subtractor: input capture, unpack, align, add, normalise/round/pack.
// Round-to-nearest-even, flush-to-zero on input and output, valid/ready with whole-pipe stall.
module fp_add_sub_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MANT_BITS = 23,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operation_select,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags
);

  localparam int unsigned E         = EXP_BITS;
  localparam int unsigned M         = MANT_BITS;
  localparam int unsigned SW        = M + 4;
  localparam int unsigned AW        = M + 5;
  localparam int unsigned LZW       = $clog2(AW + 1);
  localparam int unsigned XW        = E + 2;
  localparam int unsigned SHIFT_MAX = M + 3;
  localparam logic [E-1:0]          EXP_ONES = '1;
  localparam logic [WIDTH-1:0]      QNAN     = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
  localparam logic signed [XW-1:0]  EXP_INF  = XW'((1 << E) - 1);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic v0, v1, v2, v3;

  // Stage 0: operand capture
  logic [WIDTH-1:0] s0_a, s0_b;
  logic             s0_op;
  logic [TAG_W-1:0] s0_tag;

  // S1 unpack: classify, flush subnormals, order by magnitude
  logic [E-1:0]     ea, eb;
  logic [M-1:0]     fa, fb;
  logic             sa, sb, eff_sub;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [WIDTH-2:0] a_mag, b_mag, big_mag, small_mag;
  logic             swap, big_sign;
  logic             spec1;
  logic [WIDTH-1:0] spec_res1;
  logic [3:0]       spec_flg1;

  assign ea      = s0_a[WIDTH-2:M];
  assign eb      = s0_b[WIDTH-2:M];
  assign fa      = s0_a[M-1:0];
  assign fb      = s0_b[M-1:0];
  assign sa      = s0_a[WIDTH-1];
  assign sb      = s0_b[WIDTH-1] ^ s0_op;
  assign eff_sub = sa ^ sb;
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (ea == EXP_ONES) && (fa == '0);
  assign b_inf   = (eb == EXP_ONES) && (fb == '0);
  assign a_nan   = (ea == EXP_ONES) && (fa != '0);
  assign b_nan   = (eb == EXP_ONES) && (fb != '0);
  assign a_snan  = a_nan && !fa[M-1];
  assign b_snan  = b_nan && !fb[M-1];
  assign a_mag   = a_zero ? '0 : s0_a[WIDTH-2:0];
  assign b_mag   = b_zero ? '0 : s0_b[WIDTH-2:0];
  assign swap      = b_mag > a_mag;
  assign big_mag   = swap ? b_mag : a_mag;
  assign small_mag = swap ? a_mag : b_mag;
  assign big_sign  = swap ? sb : sa;

  always_comb begin
    spec1     = 1'b0;
    spec_res1 = '0;
    spec_flg1 = '0;
    if (a_nan || b_nan) begin
      spec1     = 1'b1;
      spec_res1 = QNAN;
      spec_flg1 = {a_snan || b_snan, 3'b000};
    end else if (a_inf && b_inf && eff_sub) begin
      spec1     = 1'b1;
      spec_res1 = QNAN;
      spec_flg1 = 4'b1000;
    end else if (a_inf) begin
      spec1     = 1'b1;
      spec_res1 = {sa, EXP_ONES, {M{1'b0}}};
    end else if (b_inf) begin
      spec1     = 1'b1;
      spec_res1 = {sb, EXP_ONES, {M{1'b0}}};
    end else if (a_zero && b_zero) begin
      spec1     = 1'b1;
      spec_res1 = {sa & sb, {(WIDTH-1){1'b0}}};
    end
  end

  logic             s1_sign, s1_sub, s1_spec;
  logic [E-1:0]     s1_exp, s1_diff;
  logic [M:0]       s1_big, s1_small;
  logic [WIDTH-1:0] s1_spec_res;
  logic [3:0]       s1_spec_flg;
  logic [TAG_W-1:0] s1_tag;

  // S2 align: shift the smaller significand right, folding lost bits into sticky
  logic [SW-1:0]   small_ext, aligned;
  logic [2*SW-1:0] small_wide;
  assign small_ext  = {s1_small, 3'b000};
  assign small_wide = {small_ext, {SW{1'b0}}} >> s1_diff;
  assign aligned    = (32'(s1_diff) >= SHIFT_MAX)
                    ? {{(SW-1){1'b0}}, |s1_small}
                    : {small_wide[2*SW-1:SW+1], small_wide[SW] | (|small_wide[SW-1:0])};

  logic             s2_sign, s2_sub, s2_spec;
  logic [E-1:0]     s2_exp;
  logic [SW-1:0]    s2_big, s2_small;
  logic [WIDTH-1:0] s2_spec_res;
  logic [3:0]       s2_spec_flg;
  logic [TAG_W-1:0] s2_tag;

  // S3 add: magnitude-ordered operands, so the difference is never negative
  function automatic logic [LZW-1:0] lzc(input logic [AW-1:0] v);
    lzc = LZW'(AW);
    for (int i = 0; i < AW; i++)
      if (v[i]) lzc = LZW'(AW - 1 - i);
  endfunction

  logic [AW-1:0] sum3;
  assign sum3 = s2_sub ? ({1'b0, s2_big} - {1'b0, s2_small})
                       : ({1'b0, s2_big} + {1'b0, s2_small});

  logic             s3_sign, s3_spec;
  logic [E-1:0]     s3_exp;
  logic [AW-1:0]    s3_sum;
  logic [LZW-1:0]   s3_lzc;
  logic [WIDTH-1:0] s3_spec_res;
  logic [3:0]       s3_spec_flg;
  logic [TAG_W-1:0] s3_tag;

  // S4 normalise, round to nearest even, pack with overflow/underflow handling
  logic [AW-1:0]          shl;
  logic [SW-1:0]          norm;
  logic [M+1:0]           mant_r;
  logic [M-1:0]           frac;
  logic signed [XW-1:0]   exp_n, exp_r;
  logic                   round_up, inexact;
  logic [WIDTH-1:0]       res4;
  logic [3:0]             flg4;

  assign shl = s3_sum << (s3_lzc - LZW'(1));

  always_comb begin
    norm     = '0;
    exp_n    = XW'(s3_exp) + XW'(1) - XW'(s3_lzc);
    round_up = 1'b0;
    inexact  = 1'b0;
    mant_r   = '0;
    frac     = '0;
    exp_r    = '0;
    res4     = '0;
    flg4     = '0;
    if (s3_sum[AW-1]) norm = {s3_sum[AW-1:2], s3_sum[1] | s3_sum[0]};
    else              norm = shl[SW-1:0];
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    inexact  = norm[2] | norm[1] | norm[0];
    mant_r   = {1'b0, norm[SW-1:3]} + (M+2)'(round_up);
    exp_r    = exp_n + XW'(mant_r[M+1]);
    frac     = mant_r[M+1] ? mant_r[M:1] : mant_r[M-1:0];
    if (s3_spec) begin
      res4 = s3_spec_res;
      flg4 = s3_spec_flg;
    end else if (s3_sum == '0) begin
      res4 = '0;
    end else if (exp_r >= EXP_INF) begin
      res4 = {s3_sign, EXP_ONES, {M{1'b0}}};
      flg4 = 4'b0101;
    end else if (exp_r[XW-1] || exp_r == '0) begin
      res4 = {s3_sign, {(WIDTH-1){1'b0}}};
      flg4 = 4'b0011;
    end else begin
      res4 = {s3_sign, exp_r[E-1:0], frac};
      flg4 = {3'b000, inexact};
    end
  end

  // Control path: valid bits and output register, all gated by advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      flags     <= '0;
    end else if (advance) begin
      v0        <= in_valid;
      v1        <= v0;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (v3) begin
        result  <= res4;
        out_tag <= s3_tag;
        flags   <= flg4;
      end
    end
  end

  // Datapath registers carry no reset; their valid bits qualify them
  always_ff @(posedge clk) begin
    if (advance) begin
      s0_a        <= a;
      s0_b        <= b;
      s0_op       <= operation_select;
      s0_tag      <= in_tag;
      s1_sign     <= big_sign;
      s1_sub      <= eff_sub;
      s1_spec     <= spec1;
      s1_exp      <= big_mag[WIDTH-2:M];
      s1_diff     <= big_mag[WIDTH-2:M] - small_mag[WIDTH-2:M];
      s1_big      <= {big_mag[WIDTH-2:M] != '0, big_mag[M-1:0]};
      s1_small    <= {small_mag[WIDTH-2:M] != '0, small_mag[M-1:0]};
      s1_spec_res <= spec_res1;
      s1_spec_flg <= spec_flg1;
      s1_tag      <= s0_tag;
      s2_sign     <= s1_sign;
      s2_sub      <= s1_sub;
      s2_spec     <= s1_spec;
      s2_exp      <= s1_exp;
      s2_big      <= {s1_big, 3'b000};
      s2_small    <= aligned;
      s2_spec_res <= s1_spec_res;
      s2_spec_flg <= s1_spec_flg;
      s2_tag      <= s1_tag;
      s3_sign     <= s2_sign;
      s3_spec     <= s2_spec;
      s3_exp      <= s2_exp;
      s3_sum      <= sum3;
      s3_lzc      <= lzc(sum3);
      s3_spec_res <= s2_spec_res;
      s3_spec_flg <= s2_spec_flg;
      s3_tag      <= s2_tag;
    end
  end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Directed bench for fp_add_sub_pipe: single operations with latency check,
// a backpressured burst, and a mid-stream reset.
module tb_fp_add_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        operation_select;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_add_sub_pipe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .a                (a),
    .b                (b),
    .operation_select (operation_select),
    .in_tag           (in_tag),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .out_tag          (out_tag),
    .flags            (flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one beat into a drained pipe and check it appears exactly 4 edges later
  task automatic run_one(input string nm, input logic [31:0] av, input logic [31:0] bv,
                         input logic op, input logic [3:0] tg,
                         input logic [31:0] er, input logic [3:0] ef);
    a = av; b = bv; operation_select = op; in_tag = tg;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) check({nm, "_early"}, 32'(out_valid), 32'd0);
    end
    check({nm, "_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_result"}, result, er);
    check({nm, "_flags"}, 32'(flags), 32'(ef));
    check({nm, "_tag"}, 32'(out_tag), 32'(tg));
  endtask

  logic [31:0] bp_b   [8];
  logic [31:0] bp_sum [8];

  initial begin
    int ri, ro, cyc;
    logic xfer_in, xfer_out;

    bp_b[0] = 32'h3F800000; bp_b[1] = 32'h40000000; bp_b[2] = 32'h40400000; bp_b[3] = 32'h40800000;
    bp_b[4] = 32'h40A00000; bp_b[5] = 32'h40C00000; bp_b[6] = 32'h40E00000; bp_b[7] = 32'h41000000;
    bp_sum[0] = 32'h40000000; bp_sum[1] = 32'h40400000; bp_sum[2] = 32'h40800000; bp_sum[3] = 32'h40A00000;
    bp_sum[4] = 32'h40C00000; bp_sum[5] = 32'h40E00000; bp_sum[6] = 32'h41000000; bp_sum[7] = 32'h41100000;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; operation_select = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_one("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 4'd3,  32'h40400000, 4'b0000);
    run_one("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 4'd4,  32'h3F800000, 4'b0001);
    run_one("tie_odd",   32'h3F800001, 32'h33800000, 1'b0, 4'd5,  32'h3F800002, 4'b0001);
    run_one("cancel",    32'h3F800000, 32'h3F800000, 1'b1, 4'd6,  32'h00000000, 4'b0000);
    run_one("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, 4'd7,  32'h80000000, 4'b0000);
    run_one("ftz_in",    32'h00400000, 32'h00000000, 1'b0, 4'd8,  32'h00000000, 4'b0000);
    run_one("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd9,  32'h7F800000, 4'b0101);
    run_one("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 4'd10, 32'h7FC00000, 4'b1000);
    run_one("snan",      32'h7F800001, 32'h3F800000, 1'b0, 4'd11, 32'h7FC00000, 4'b1000);
    run_one("qnan",      32'h7FC00000, 32'h3F800000, 1'b0, 4'd12, 32'h7FC00000, 4'b0000);
    run_one("inf_p_one", 32'h7F800000, 32'h3F800000, 1'b0, 4'd13, 32'h7F800000, 4'b0000);
    run_one("sub_3_1",   32'h40400000, 32'h3F800000, 1'b1, 4'd14, 32'h40000000, 4'b0000);
    run_one("underflow", 32'h00800000, 32'h00800001, 1'b1, 4'd15, 32'h80000000, 4'b0011);
    @(posedge clk); #1;

    // Backpressured burst: 1.0 + k for k = 1..8, stall the consumer for 3 cycles
    ri = 0; ro = 0; cyc = 0;
    a = 32'h3F800000; operation_select = 1'b0;
    b = bp_b[0]; in_tag = 4'd0; in_valid = 1'b1;
    while (ro < 8 && cyc < 100) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'(out_ready));
      xfer_in  = in_valid && in_ready;
      xfer_out = out_valid && out_ready;
      if (out_valid) begin
        check("bp_tag", 32'(out_tag), 32'(ro));
        check("bp_result", result, bp_sum[ro]);
        check("bp_flags", 32'(flags), 32'd0);
      end
      if (xfer_out) ro++;
      @(posedge clk); #1;
      if (xfer_in) begin
        ri++;
        if (ri < 8) begin
          b = bp_b[ri]; in_tag = 4'(ri);
        end else begin
          in_valid = 1'b0;
        end
      end
      cyc++;
    end
    check("bp_count", 32'(ro), 32'd8);
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("bp_no_extra", 32'(out_valid), 32'd0);
    end

    // Mid-stream reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      a = 32'h3F800000; b = bp_b[i]; in_tag = 4'(i + 1); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; in_tag = 4'd9;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_result", result, 32'd0);
    check("mrst_tag", 32'(out_tag), 32'd0);
    check("mrst_flags", 32'(flags), 32'd0);
    repeat (8) begin
      @(posedge clk); #1;
      check("mrst_flushed", 32'(out_valid), 32'd0);
    end
    run_one("post_rst", 32'h40000000, 32'h40000000, 1'b0, 4'd2, 32'h40800000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_add_sub_pipe.md
# fp_add_sub_pipe

Parametrised, pipelined IEEE-754 floating-point adder/subtractor with valid/ready flow control, round-to-nearest-even, exception flags and a pass-through tag. It is the clocked successor of the combinational `add_sub_main` datapath and sits between an operand-issue stage and a result-writeback stage. It accepts one operation per cycle. Results leave in issue order after a fixed 4-stage latency, or later if the consumer applies backpressure.

## Interface
Parameters:
- `WIDTH`, 32: total format width; must equal 1 + `EXP_BITS` + `MANT_BITS`.
- `EXP_BITS`, 8: exponent field width; bias is 2^(`EXP_BITS`-1)-1.
- `MANT_BITS`, 23: stored fraction width, without the hidden bit.
- `TAG_W`, 4: width of the user tag carried alongside each operation.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand beat presented.
- `in_ready`  out  1  block accepts the beat this cycle.
- `a`  in  `WIDTH`  operand A.
- `b`  in  `WIDTH`  operand B.
- `operation_select`  in  1  0 = A+B, 1 = A−B.
- `in_tag`  in  `TAG_W`  user tag.
- `out_valid`  out  1  result beat presented.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  `WIDTH`  rounded result.
- `out_tag`  out  `TAG_W`  tag of the result's operation.
- `flags`  out  4  {invalid, overflow, underflow, inexact}.

## Operation
- Transfer rule: a transfer occurs when valid and ready are both high on a rising edge.
- Subtraction: B's sign is inverted at S1 when `operation_select`=1, then the operation proceeds as an addition.
- S1, unpack:
  - Subnormal inputs are flushed to a signed zero (FTZ).
  - Classify each operand as zero, normal, infinity, qNaN or sNaN.
  - Swap so that |A| ≥ |B|, comparing exponent first, then fraction.
  - Compute the exponent difference.
- S2, align:
  - Right-shift the smaller significand by the exponent difference, producing guard, round and sticky bits.
  - Shifts ≥ `MANT_BITS`+3 collapse the operand into sticky.
- S3, add:
  - Add or subtract significands at width `MANT_BITS`+5, which includes the carry bit.
  - Compute the leading-zero count.
- S4, normalise/round/pack:
  - Normalise: shift right by 1 on carry-out, otherwise shift left by the leading-zero count, adjusting the exponent.
  - Round to nearest, ties to even. A rounding carry renormalises.
- Special-value results:
  - Any NaN input → canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0). Invalid is set only for an sNaN input.
  - ∞ − ∞ (effective subtraction of infinities) → canonical qNaN, invalid.
  - ∞ ± finite → that infinity; no flags.
  - Exact zero from operands of opposite sign → +0. (−0)+(−0) → −0.
  - Exponent overflow after rounding → signed infinity; overflow and inexact set.
  - Result below the minimum normal → signed zero; underflow and inexact set (FTZ output).
  - Inexact is set whenever any discarded bit (guard/round/sticky) is nonzero.
- `in_tag` travels unmodified alongside its operation.

## Timing
- Pipeline advance: `advance` = !`out_valid` || `out_ready`.
  - `in_ready` = `advance`, combinational.
  - When `advance` is low, all four stages hold their contents.
- Latency: a beat accepted at edge N is presented on `out_valid` after edge N+4 if there is no stall. Each stall cycle adds one cycle.
- Throughput: one result per cycle with `out_ready` held high.
- Bubbles: cycles with no input transfer propagate as invalid stages. They do not stall the pipeline.
- Output stability: while `out_valid`=1 and `out_ready`=0, `result`, `out_tag` and `flags` hold stable.
- Reset (`rst_n`=0 at an edge):
  - All stage valid bits clear, discarding in-flight operations, including when asserted mid-operation.
  - After that edge: `out_valid`=0, `result`=0, `out_tag`=0, `flags`=0.
  - `in_ready`=1 from the first cycle after reset, since `out_valid`=0.
- `in_valid` is ignored while `rst_n`=0.

## Test plan
- 0x3F800000 + 0x40000000, op=0, tag 3 → `result`=0x40400000, `flags`=0, `out_tag`=3, exactly 4 cycles after acceptance.
- Rounding ties:
  - 0x3F800000 + 0x33800000 → 0x3F800000, inexact (tie rounds to even).
  - 0x3F800001 + 0x33800000 → 0x3F800002, inexact.
- Cancellation and signed zero:
  - 0x3F800000 − 0x3F800000 → 0x00000000, `flags`=0.
  - 0x80000000 + 0x80000000 → 0x80000000.
  - 0x00400000 + 0x00000000 → 0x00000000 (FTZ).
- Exceptions:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow and inexact.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid.
  - 0x7F800001 + 0x3F800000 → 0x7FC00000, invalid.
- Backpressure: 8 back-to-back beats with tags 0–7; drop `out_ready` for 3 cycles mid-stream.
  - `in_ready` falls in the same cycles.
  - No beat is lost or duplicated; tags emerge 0–7 in order with correct sums.
- Reset mid-stream: assert `rst_n`=0 for one edge with 3 operations in flight → `out_valid`=0 next cycle, none of the 3 results ever appear, and a new beat afterwards returns after 4 cycles.
